// File: rtl/collision_scorer.sv
// Snapshots the enemy slot bus and scans one slot per cycle for a box overlap with the player; keeps score, hiscore and a latched game_over.
// Score lands SLOTS+3 edges after IDLE sees start (+1 per paused SCAN cycle); pause freezes the scan, start low aborts it.
module collision_scorer #(
    parameter int SLOTS      = 4,
    parameter int TYPE_W     = 2,
    parameter int X_W        = 10,
    parameter int Y_W        = 10,
    parameter int W_W        = 8,
    parameter int H_W        = 8,
    parameter int ENEMY_TYPE = 1,
    parameter int SCORE_W    = 16,
    localparam int REC_W     = TYPE_W + X_W + Y_W + W_W + H_W,
    localparam int IDX_W     = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic                     clk3,
    input  logic                     reset,
    input  logic                     pause,
    input  logic                     start,
    input  logic                     restart,
    input  logic [SLOTS*REC_W-1:0]   gamedata,
    input  logic [REC_W-1:0]         player,
    output logic                     game_over,
    output logic [SCORE_W-1:0]       score,
    output logic [SCORE_W-1:0]       hiscore,
    output logic [IDX_W-1:0]         hit_slot,
    output logic                     busy
);

    localparam int XS    = ((X_W > W_W) ? X_W : W_W) + 1;
    localparam int YS    = ((Y_W > H_W) ? Y_W : H_W) + 1;
    localparam int PREC_W = REC_W - TYPE_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_SCAN,
        S_DONE,
        S_OVER
    } state_t;

    state_t                   state_q, state_d;
    logic [SLOTS*REC_W-1:0]   snap_bus_q, snap_bus_d;
    logic [PREC_W-1:0]        snap_player_q, snap_player_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     hit_q, hit_d;
    logic [IDX_W-1:0]         hit_slot_q, hit_slot_d;
    logic                     game_over_q, game_over_d;
    logic [SCORE_W-1:0]       score_q, score_d;
    logic [SCORE_W-1:0]       hiscore_q, hiscore_d;
    logic                     busy_q, busy_d;

    // The player's type field carries no meaning for the overlap test.
    logic unused_player_type;
    assign unused_player_type = ^player[TYPE_W-1:0];

    logic [REC_W-1:0] slot_rec [SLOTS];
    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        assign slot_rec[g] = snap_bus_q[g*REC_W +: REC_W];
    end

    logic [REC_W-1:0]  enemy_rec;
    logic [TYPE_W-1:0] e_type;
    logic [XS-1:0]     ex, ew, px, pw;
    logic [YS-1:0]     ey, eh, py, ph;
    logic              hit_now;

    // Operands widened by one bit so x+w and y+h never wrap.
    always_comb begin
        enemy_rec = slot_rec[idx_q];
        e_type    = enemy_rec[TYPE_W-1:0];
        ex        = XS'(enemy_rec[TYPE_W +: X_W]);
        ey        = YS'(enemy_rec[TYPE_W+X_W +: Y_W]);
        ew        = XS'(enemy_rec[TYPE_W+X_W+Y_W +: W_W]);
        eh        = YS'(enemy_rec[TYPE_W+X_W+Y_W+W_W +: H_W]);
        px        = XS'(snap_player_q[0 +: X_W]);
        py        = YS'(snap_player_q[X_W +: Y_W]);
        pw        = XS'(snap_player_q[X_W+Y_W +: W_W]);
        ph        = YS'(snap_player_q[X_W+Y_W+W_W +: H_W]);
        hit_now   = (e_type == TYPE_W'(ENEMY_TYPE))
                  && (ex < px + pw) && (px < ex + ew)
                  && (ey < py + ph) && (py < ey + eh);
    end

    always_comb begin
        state_d       = state_q;
        snap_bus_d    = snap_bus_q;
        snap_player_d = snap_player_q;
        idx_d         = idx_q;
        hit_d         = hit_q;
        hit_slot_d    = hit_slot_q;
        game_over_d   = game_over_q;
        score_d       = score_q;
        hiscore_d     = hiscore_q;

        case (state_q)
            S_IDLE: begin
                if (start && !pause) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else begin
                    snap_bus_d    = gamedata;
                    snap_player_d = player[REC_W-1:TYPE_W];
                    hit_d         = 1'b0;
                    idx_d         = '0;
                    state_d       = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else if (!pause) begin
                    // First hit wins: lowest slot index is reported.
                    if (hit_now && !hit_q) begin
                        hit_d      = 1'b1;
                        hit_slot_d = idx_q;
                    end
                    if (idx_q == IDX_W'(SLOTS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else if (hit_q) begin
                    game_over_d = 1'b1;
                    if (score_q > hiscore_q) begin
                        hiscore_d = score_q;
                    end
                    state_d = S_OVER;
                end else begin
                    if (score_q != {SCORE_W{1'b1}}) begin
                        score_d = score_q + 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            S_OVER: begin
                if (restart) begin
                    state_d     = S_IDLE;
                    score_d     = '0;
                    game_over_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outside OVER a restart only wipes the score, overriding any increment.
        if (restart && (state_q != S_OVER)) begin
            score_d = '0;
        end

        busy_d = (state_d == S_CAPTURE) || (state_d == S_SCAN) || (state_d == S_DONE);
    end

    always_ff @(posedge clk3 or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            snap_bus_q    <= '0;
            snap_player_q <= '0;
            idx_q         <= '0;
            hit_q         <= 1'b0;
            hit_slot_q    <= '0;
            game_over_q   <= 1'b0;
            score_q       <= '0;
            hiscore_q     <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            snap_bus_q    <= snap_bus_d;
            snap_player_q <= snap_player_d;
            idx_q         <= idx_d;
            hit_q         <= hit_d;
            hit_slot_q    <= hit_slot_d;
            game_over_q   <= game_over_d;
            score_q       <= score_d;
            hiscore_q     <= hiscore_d;
            busy_q        <= busy_d;
        end
    end

    assign game_over = game_over_q;
    assign score     = score_q;
    assign hiscore   = hiscore_q;
    assign hit_slot  = hit_slot_q;
    assign busy      = busy_q;

endmodule
